// File: rtl/lsu_mem_req_sequencer_pkg.sv
// Shared sizing, FSM encoding and op metadata for the LSU memory request sequencer.
// Pure declarations: no logic, no latency, no flow control.
package lsu_mem_req_sequencer_pkg;

  localparam int LSU_NUM_LANES = 64;
  localparam int LSU_WORD_W    = 32;
  localparam int LSU_TAG_W     = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic                 is_load;
    logic [LSU_TAG_W-1:0] tag;
  } op_meta_t;

endpackage

// File: rtl/lsu_mem_req_sequencer_lane_mux.sv
// Combinational per-lane select of address and store data by lane counter (0 cycles).
// No flow control; the select input is the sequencer's registered lane counter.
module lsu_lane_mux
  import lsu_mem_req_sequencer_pkg::*;
#(
  parameter int NUM_LANES = LSU_NUM_LANES,
  parameter int WORD_W    = LSU_WORD_W,
  parameter int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic [NUM_LANES*WORD_W-1:0] addr_vec,
  input  logic [NUM_LANES*WORD_W-1:0] wdata_vec,
  input  logic [LANE_W-1:0]           lane,
  output logic [WORD_W-1:0]           lane_addr,
  output logic [WORD_W-1:0]           lane_wdata
);

  logic [WORD_W-1:0] addr_arr  [NUM_LANES];
  logic [WORD_W-1:0] wdata_arr [NUM_LANES];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign addr_arr[i]  = addr_vec[i*WORD_W +: WORD_W];
    assign wdata_arr[i] = wdata_vec[i*WORD_W +: WORD_W];
  end

  assign lane_addr  = addr_arr[lane];
  assign lane_wdata = wdata_arr[lane];

endmodule

// File: rtl/lsu_mem_req_sequencer.sv
// Serialises one wavefront load/store into per-lane memory requests, lane 0 first, one lane per ack or skip.
// Inactive lanes take one cycle; busy ops hold issue_ready low until the cycle after the done pulse.
module lsu_mem_req_sequencer
  import lsu_mem_req_sequencer_pkg::*;
#(
  parameter int NUM_LANES = LSU_NUM_LANES,
  parameter int WORD_W    = LSU_WORD_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic                        issue_is_load,
  input  logic [LSU_TAG_W-1:0]        issue_tag,
  input  logic [NUM_LANES*WORD_W-1:0] issue_addr,
  input  logic [NUM_LANES*WORD_W-1:0] issue_wr_data,
  input  logic [NUM_LANES-1:0]        issue_exec,
  output logic                        mem_rd_en,
  output logic                        mem_wr_en,
  output logic [WORD_W-1:0]           mem_addr,
  output logic [WORD_W-1:0]           mem_wr_data,
  output logic [LSU_TAG_W-1:0]        mem_tag,
  input  logic                        mem_ack,
  input  logic [WORD_W-1:0]           mem_rd_data,
  output logic [WORD_W-1:0]           wb_rd_data,
  output logic                        load_wb,
  output logic                        done,
  output logic [LSU_TAG_W-1:0]        done_tag,
  output logic                        done_is_load
);

  localparam int                 LANE_W    = $clog2(NUM_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  logic [1:0]                  state_q, state_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic [NUM_LANES*WORD_W-1:0] addr_q, addr_d;
  logic [NUM_LANES*WORD_W-1:0] wdata_q, wdata_d;
  logic [NUM_LANES-1:0]        exec_q, exec_d;
  op_meta_t                    meta_q, meta_d;

  logic [LANE_W-1:0] lane_nxt;
  logic              req_active;
  logic              lane_fin;
  logic [WORD_W-1:0] lane_addr;
  logic [WORD_W-1:0] lane_wdata;

  assign lane_nxt   = lane_q + LANE_W'(1);
  assign req_active = (state_q == ST_REQ);
  // A lane retires on its ack, or unconditionally after its single skip cycle.
  assign lane_fin   = (state_q == ST_SKIP) || (req_active && mem_ack);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    exec_d  = exec_q;
    meta_d  = meta_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid) begin
          addr_d         = issue_addr;
          wdata_d        = issue_wr_data;
          exec_d         = issue_exec;
          meta_d.is_load = issue_is_load;
          meta_d.tag     = issue_tag;
          lane_d         = '0;
          state_d        = issue_exec[0] ? ST_REQ : ST_SKIP;
        end
      end
      ST_REQ, ST_SKIP: begin
        if (lane_fin) begin
          if (lane_q == LAST_LANE) begin
            state_d = ST_DONE;
          end else begin
            lane_d  = lane_nxt;
            state_d = exec_q[lane_nxt] ? ST_REQ : ST_SKIP;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      exec_q  <= '0;
      meta_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      exec_q  <= exec_d;
      meta_q  <= meta_d;
    end
  end

  lsu_lane_mux #(
    .NUM_LANES (NUM_LANES),
    .WORD_W    (WORD_W),
    .LANE_W    (LANE_W)
  ) u_lane_mux (
    .addr_vec   (addr_q),
    .wdata_vec  (wdata_q),
    .lane       (lane_q),
    .lane_addr  (lane_addr),
    .lane_wdata (lane_wdata)
  );

  assign issue_ready = (state_q == ST_IDLE);

  assign mem_rd_en   = req_active && meta_q.is_load;
  assign mem_wr_en   = req_active && !meta_q.is_load;
  assign mem_addr    = req_active ? lane_addr : '0;
  assign mem_wr_data = mem_wr_en ? lane_wdata : '0;
  assign mem_tag     = req_active ? meta_q.tag : '0;

  // Skipped load lanes still shift a zero word so the downstream register stays lane-aligned.
  assign load_wb    = meta_q.is_load && ((req_active && mem_ack) || (state_q == ST_SKIP));
  assign wb_rd_data = (load_wb && req_active) ? mem_rd_data : '0;

  assign done         = (state_q == ST_DONE);
  assign done_tag     = done ? meta_q.tag : '0;
  assign done_is_load = done && meta_q.is_load;

endmodule

// File: doc/lsu_mem_req_sequencer.md
LSU_MEM_REQ_SEQUENCER -- requirements
Module: lsu_mem_req_sequencer

Interface
REQ-001 SHALL have parameter NUM_LANES, default 64: lanes per wavefront op.
REQ-002 SHALL have parameter WORD_W, default 32: bits per lane word.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port issue_valid, input, 1: op offered.
REQ-006 SHALL have port issue_ready, output, 1: op accepted when valid and ready are both high.
REQ-007 SHALL have port issue_is_load, input, 1: 1 = load, 0 = store.
REQ-008 SHALL have port issue_tag, input, 7: op tag.
REQ-009 SHALL have port issue_addr, input, 2048: lane n address at [32n+31:32n].
REQ-010 SHALL have port issue_wr_data, input, 2048: store data, same lane packing.
REQ-011 SHALL have port issue_exec, input, 64: lane active mask.
REQ-012 SHALL have ports mem_rd_en and mem_wr_en, output, 1 each: memory request.
REQ-013 SHALL have ports mem_addr, output, 32; mem_wr_data, output, 32; mem_tag, output, 7: request payload.
REQ-014 SHALL have ports mem_ack, input, 1; mem_rd_data, input, 32: memory response.
REQ-015 SHALL have ports wb_rd_data, output, 32; load_wb, output, 1: word strobe to the downstream LSU writeback shift flops.
REQ-016 SHALL have ports done, output, 1; done_tag, output, 7; done_is_load, output, 1: op completion.

Function
REQ-017 SHALL implement states IDLE, REQ, SKIP and DONE, with a 6-bit lane counter.
REQ-018 SHALL drive issue_ready high only in IDLE.
REQ-019 SHALL latch issue_addr, issue_wr_data, issue_exec, issue_tag and issue_is_load on accept, and SHALL ignore input changes afterwards.
REQ-020 SHALL, on accept, clear the lane counter to 0 and enter REQ if exec[0] is set, else SKIP.
REQ-021 SHALL, in REQ, assert mem_rd_en (load) or mem_wr_en (store), with mem_addr, mem_wr_data and mem_tag for the current lane, held stable until mem_ack is sampled high; an ack may arrive in the first REQ cycle.
REQ-022 SHALL, on a load ack, pulse load_wb for exactly that cycle with wb_rd_data = mem_rd_data.
REQ-023 SHALL never pulse load_wb for store ops.
REQ-024 SHALL, in SKIP (inactive lane), stay exactly 1 cycle with no memory request, and for loads pulse load_wb with wb_rd_data = 0.
REQ-025 SHALL, for every load, emit exactly 64 load_wb pulses in lane order 0..63, so lane 0 ends at bits [31:0] of the downstream register.
REQ-026 SHALL, after the ack or SKIP of lane n < 63, increment the counter and go to REQ or SKIP per exec[n+1] on the next cycle.
REQ-027 SHALL, after lane 63 completes, enter DONE, pulse done for 1 cycle with done_tag and done_is_load, then return to IDLE.
REQ-028 SHALL ignore mem_ack in IDLE, SKIP and DONE.
REQ-029 SHALL complete an exec = 0 op 65 cycles after accept: 64 SKIP cycles plus DONE.
REQ-030 SHALL hold wb_rd_data at 0 whenever load_wb is low.

Reset
REQ-031 SHALL, on rst (synchronous, active-high), enter IDLE, clear the lane counter and latched op, and drive all outputs to 0 except issue_ready, which is 1 after reset release.
REQ-032 SHALL, on rst mid-op, abandon the op: no done pulse, no further load_wb, and a late ack is ignored per REQ-028.

Structure
REQ-033 SHALL place the state encoding, NUM_LANES, WORD_W and the tag width (7) in a shared LSU package.
REQ-034 SHALL implement lane selection of address and write data in one sub-module, lsu_lane_mux (64:1 mux, 32 bits wide, indexed by the lane counter).

Verification
REQ-035 SHALL cover: load, exec all ones, ack in the first REQ cycle, memory returns 0x1000+n for lane n -> 64 load_wb pulses with values 0x1000..0x103F, done at cycle 65, done_tag = issue_tag.
REQ-036 SHALL cover: load, exec = 0x5 -> requests only for lanes 0 and 2; load_wb data 0x1000, 0, 0x1002, then 61 zeros; 64 pulses total.
REQ-037 SHALL cover: store, exec = 0x8000000000000001, ack delay 3 cycles -> mem_wr_en for lanes 0 and 63 only with correct addr and data, request stable until ack, no load_wb, then done with done_is_load = 0.
REQ-038 SHALL cover: exec = 0 load -> 64 zero pulses, done exactly 65 cycles after accept.
REQ-039 SHALL cover: rst asserted during lane 10 REQ, then ack asserted -> outputs 0, no done, next op accepted and run correctly.
REQ-040 SHALL cover: issue_valid held high across back-to-back ops -> second op accepted only on the first IDLE cycle after DONE; mem_ack pulse while IDLE -> no effect.
